// File: rtl/systolic_job_ctrl_if.sv
// Result handshake and systolic-array lane bundle between the job controller and its neighbours.
// master = controller side, slave = host/array side.
interface systolic_job_ctrl_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned data_width = 8,
  parameter int unsigned acc_width  = 16
);
  localparam int unsigned LANE_W = N * N * data_width;
  localparam int unsigned RES_W  = N * N * acc_width;

  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              arr_rst;
  logic              arr_en;
  logic              arr_locked;
  logic [LANE_W-1:0] arr_a_flat;
  logic [LANE_W-1:0] arr_b_flat;
  logic [RES_W-1:0]  arr_c_flat;

  modport master (
    output res_valid, res_data, arr_rst, arr_en, arr_a_flat, arr_b_flat,
    input  res_ready, arr_locked, arr_c_flat
  );

  modport slave (
    input  res_valid, res_data, arr_rst, arr_en, arr_a_flat, arr_b_flat,
    output res_ready, arr_locked, arr_c_flat
  );
endinterface

// File: rtl/systolic_job_ctrl.sv
// Job controller for an NxN output-stationary systolic array: buffers A/B, clears and
// locks the array, streams skewed wavefronts with bubbles, drains, captures and returns C.
module systolic_job_ctrl #(
  parameter int unsigned N            = 8,
  parameter int unsigned data_width   = 8,
  parameter int unsigned acc_width    = 16,
  parameter int unsigned BUBBLE       = 1,
  parameter int unsigned CLR_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 20,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_wr_en,
  input  logic                    b_wr_en,
  input  logic [$clog2(N)-1:0]    wr_row,
  input  logic [N*data_width-1:0] wr_data,
  output logic                    wr_err,
  input  logic                    start,
  output logic                    busy,
  output logic                    lock_err,
  systolic_job_ctrl_if.master     bus
);

  localparam int unsigned ROW_W   = $clog2(N);
  localparam int unsigned LANE_W  = N * N * data_width;
  localparam int unsigned RES_W   = N * N * acc_width;
  localparam int unsigned T_LAST  = 2 * N - 2;
  localparam int unsigned T_W     = $clog2(T_LAST + 1);
  localparam int unsigned PH_W    = (BUBBLE > 0) ? $clog2(BUBBLE + 1) : 1;
  localparam int unsigned CNT_MAX0 = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_MAX  = (LOCK_TIMEOUT > CNT_MAX0) ? LOCK_TIMEOUT : CNT_MAX0;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    LOCK  = 3'd2,
    FEED  = 3'd3,
    DRAIN = 3'd4,
    CAPT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [T_W-1:0]     t, t_n;
  logic [PH_W-1:0]    ph, ph_n;
  logic               lock_to;

  logic               busy_d, arr_en_d, arr_rst_d, res_valid_d;
  logic [LANE_W-1:0]  a_lane_d, b_lane_d;
  logic               arr_en_q, arr_rst_q, res_valid_q;
  logic [LANE_W-1:0]  a_lane_q, b_lane_q;
  logic [RES_W-1:0]   res_data_q;

  // Row-major operand buffers; element j of a row sits at [j] of the packed row.
  logic [N-1:0][data_width-1:0] a_buf [N];
  logic [N-1:0][data_width-1:0] b_buf [N];

  assign bus.arr_en     = arr_en_q;
  assign bus.arr_rst    = arr_rst_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.arr_a_flat = a_lane_q;
  assign bus.arr_b_flat = b_lane_q;

  // State, sequencing counters and outputs; outputs are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      t           <= '0;
      ph          <= '0;
      busy        <= 1'b0;
      arr_en_q    <= 1'b0;
      arr_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      a_lane_q    <= '0;
      b_lane_q    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      t           <= t_n;
      ph          <= ph_n;
      busy        <= busy_d;
      arr_en_q    <= arr_en_d;
      arr_rst_q   <= arr_rst_d;
      res_valid_q <= res_valid_d;
      a_lane_q    <= a_lane_d;
      b_lane_q    <= b_lane_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    t_n     = t;
    ph_n    = ph;
    lock_to = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = CLR;
          cnt_n   = '0;
        end
      end
      CLR: begin
        if (cnt == CNT_W'(CLR_CYCLES - 1)) begin
          state_n = LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LOCK: begin
        if (bus.arr_locked) begin
          state_n = FEED;
          t_n     = '0;
          ph_n    = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_n = IDLE;
          lock_to = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      FEED: begin
        if (ph == PH_W'(BUBBLE)) begin
          ph_n = '0;
          if (t == T_W'(T_LAST)) begin
            state_n = DRAIN;
            cnt_n   = '0;
          end else begin
            t_n = t + T_W'(1);
          end
        end else begin
          ph_n = ph + PH_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_n = CAPT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CAPT: state_n = DONE;
      DONE: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output decode for the upcoming cycle, including the diagonal wavefront skew.
  always_comb begin
    busy_d      = (state_n != IDLE);
    arr_en_d    = (state_n == LOCK) || (state_n == FEED) || (state_n == DRAIN);
    arr_rst_d   = (state_n == CLR);
    res_valid_d = (state_n == DONE);
    a_lane_d    = '0;
    b_lane_d    = '0;
    if ((state_n == FEED) && (ph_n == '0)) begin
      for (int i = 0; i < int'(N); i++) begin
        if ((int'(t_n) >= i) && ((int'(t_n) - i) < int'(N))) begin
          a_lane_d[i*data_width +: data_width] = a_buf[ROW_W'(i)][ROW_W'(int'(t_n) - i)];
          b_lane_d[i*data_width +: data_width] = b_buf[ROW_W'(int'(t_n) - i)][ROW_W'(i)];
        end
      end
    end
  end

  // Operand buffers, error flags and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(N); r++) begin
        a_buf[r] <= '0;
        b_buf[r] <= '0;
      end
      wr_err     <= 1'b0;
      lock_err   <= 1'b0;
      res_data_q <= '0;
    end else begin
      wr_err <= (a_wr_en || b_wr_en) && (state != IDLE);
      if (state == IDLE) begin
        if (a_wr_en) a_buf[wr_row] <= wr_data;
        if (b_wr_en) b_buf[wr_row] <= wr_data;
      end
      if ((state == IDLE) && start) begin
        lock_err <= 1'b0;
      end else if (lock_to) begin
        lock_err <= 1'b1;
      end
      if (state == CAPT) res_data_q <= bus.arr_c_flat;
    end
  end

endmodule

// File: tb/tb_systolic_job_ctrl.sv
// Directed bench for systolic_job_ctrl with a behavioural 8x8 output-stationary array
// whose per-hop delay matches the one-bubble wavefront spacing.
module tb_systolic_job_ctrl;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_wr_en, b_wr_en, start;
  logic [2:0]        wr_row;
  logic [N*DW-1:0]   wr_data;
  logic              wr_err, busy, lock_err;

  int checks   = 0;
  int failures = 0;

  int ga [N][N];
  int gb [N][N];
  int gc [N][N];
  logic [N*N*AW-1:0] golden_flat;

  systolic_job_ctrl_if #(.N(N), .data_width(DW), .acc_width(AW)) bus ();

  systolic_job_ctrl #(.N(N), .data_width(DW), .acc_width(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_wr_en  (a_wr_en),
    .b_wr_en  (b_wr_en),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .start    (start),
    .busy     (busy),
    .lock_err (lock_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Array model: each PE forwards operands through two stages, so a hop costs one
  // data cycle plus one bubble and the skewed operands meet at the right PE.
  logic [DW-1:0] pa1 [N][N];
  logic [DW-1:0] pa2 [N][N];
  logic [DW-1:0] pb1 [N][N];
  logic [DW-1:0] pb2 [N][N];
  logic [AW-1:0] acc [N][N];
  logic [DW-1:0] a_in [N][N+1];
  logic [DW-1:0] b_in [N+1][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = bus.arr_a_flat[i*DW +: DW];
      b_in[0][i] = bus.arr_b_flat[i*DW +: DW];
      for (int j = 0; j < N; j++) begin
        a_in[i][j+1] = pa2[i][j];
        b_in[i+1][j] = pb2[i][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (bus.arr_rst) begin
          pa1[i][j] <= '0;
          pa2[i][j] <= '0;
          pb1[i][j] <= '0;
          pb2[i][j] <= '0;
          acc[i][j] <= '0;
        end else if (bus.arr_en) begin
          pa1[i][j] <= a_in[i][j];
          pa2[i][j] <= pa1[i][j];
          pb1[i][j] <= b_in[i][j];
          pb2[i][j] <= pb1[i][j];
          acc[i][j] <= acc[i][j] + AW'(a_in[i][j]) * AW'(b_in[i][j]);
        end
      end
    end
  end

  always_comb begin
    bus.arr_c_flat = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.arr_c_flat[(i*N+j)*AW +: AW] = acc[i][j];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag);
    int bad;
    logic [AW-1:0] o, e;
    bad = -1;
    o = '0;
    e = '0;
    for (int k = 0; k < N*N; k++) begin
      if ((bus.res_data[k*AW +: AW] !== golden_flat[k*AW +: AW]) && (bad < 0)) begin
        bad = k;
        o = bus.res_data[k*AW +: AW];
        e = golden_flat[k*AW +: AW];
      end
    end
    checks++;
    assert (bus.res_data === golden_flat) else begin
      failures++;
      $error("FAIL %s elem=%0d observed=%0h expected=%0h", tag, bad, o, e);
    end
  endtask

  function automatic logic [AW-1:0] res_elem(input int i, input int j);
    return bus.res_data[(i*N+j)*AW +: AW];
  endfunction

  task automatic load_ops();
    for (int r = 0; r < N; r++) begin
      a_wr_en = 1'b1;
      b_wr_en = 1'b0;
      wr_row  = 3'(r);
      for (int c = 0; c < N; c++) wr_data[c*DW +: DW] = DW'(ga[r][c]);
      tick();
      a_wr_en = 1'b0;
      b_wr_en = 1'b1;
      for (int c = 0; c < N; c++) wr_data[c*DW +: DW] = DW'(gb[r][c]);
      tick();
    end
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  // Pulse start and wait (bounded) for res_valid; n = cycles after the start edge.
  task automatic run_job(output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ((n < 200) && (bus.res_valid !== 1'b1)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    bit seen_valid;

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ga[i][j] = 8*i + j + 1;
        gb[i][j] = 64 - (8*i + j);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        gc[i][j] = 0;
        for (int k = 0; k < N; k++) gc[i][j] += ga[i][k] * gb[k][j];
        golden_flat[(i*N+j)*AW +: AW] = AW'(gc[i][j]);
      end

    rst = 1'b1; a_wr_en = 1'b0; b_wr_en = 1'b0; wr_row = '0; wr_data = '0;
    start = 1'b0; bus.res_ready = 1'b0; bus.arr_locked = 1'b1;
    tick(); tick();

    check("rst_busy", busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_arr_en", bus.arr_en, 0);
    check("rst_arr_rst", bus.arr_rst, 1);
    check("rst_lock_err", lock_err, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_lanes", |{bus.arr_a_flat, bus.arr_b_flat}, 0);
    check("rst_res_data", |bus.res_data, 0);
    rst = 1'b0;
    tick();
    check("post_rst_arr_rst", bus.arr_rst, 0);

    load_ops();

    // Job 1: latency, wavefront shape, result, then a held-off handshake.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("j1_busy_after_start", busy, 1);
    n = 0;
    while ((n < 200) && (bus.res_valid !== 1'b1)) begin
      tick();
      n++;
      if (n == 1) check("j1_clr_arr_rst", bus.arr_rst, 1);
      if (n == 9) begin
        check("j1_t3_arr_en", bus.arr_en, 1);
        check("j1_t3_a_lanes", bus.arr_a_flat[63:0], 64'h0000_0000_1912_0B04);
        check("j1_t3_b_lanes", bus.arr_b_flat[63:0], 64'h0000_0000_3D36_2F28);
        check("j1_t3_upper_zero", |{bus.arr_a_flat[N*N*DW-1:64], bus.arr_b_flat[N*N*DW-1:64]}, 0);
      end
      if (n == 10) check("j1_t3_bubble", |{bus.arr_a_flat, bus.arr_b_flat}, 0);
    end
    check("j1_latency", 64'(n), 64'd54);
    check("j1_c00", res_elem(0, 0), 960);
    check("j1_c07", res_elem(0, 7), 708);
    check("j1_c70", res_elem(7, 0), 17088);
    check("j1_c77", res_elem(7, 7), 13700);
    check_res("j1_result");
    check("j1_done_arr_en", bus.arr_en, 0);

    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      tick();
      start = 1'b0;
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_busy", busy, 1);
      check_res("hold_res_data");
    end
    bus.res_ready = 1'b1;
    tick();
    check("hs_res_valid_drop", bus.res_valid, 0);
    check("hs_busy_drop", busy, 0);
    tick();
    check("ignored_start_idle", busy, 0);
    check("idle_keeps_result", res_elem(7, 7), 13700);

    // Job 2: dropped write during FEED, res_ready already high on entry to DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ((n < 200) && (bus.res_valid !== 1'b1)) begin
      tick();
      n++;
      if (n == 10) begin
        a_wr_en = 1'b1;
        wr_row  = 3'd0;
        wr_data = '1;
      end
      if (n == 11) begin
        check("j2_wr_err_pulse", wr_err, 1);
        a_wr_en = 1'b0;
      end
      if (n == 12) check("j2_wr_err_clear", wr_err, 0);
    end
    check("j2_latency", 64'(n), 64'd54);
    check_res("j2_result");
    tick();
    check("j2_one_cycle_hs", bus.res_valid, 0);
    check("j2_idle", busy, 0);

    // Job 3: array never locks.
    bus.arr_locked = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    seen_valid = 1'b0;
    while ((n < 400) && (busy === 1'b1)) begin
      tick();
      n++;
      if (bus.res_valid === 1'b1) seen_valid = 1'b1;
    end
    check("j3_timeout_cycles", 64'(n), 64'd257);
    check("j3_lock_err", lock_err, 1);
    check("j3_no_result", 64'(seen_valid), 0);
    check("j3_arr_en_off", bus.arr_en, 0);

    // Job 4: start clears lock_err; reset during wavefront 5.
    bus.arr_locked = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("j4_lock_err_cleared", lock_err, 0);
    n = 0;
    while (n < 13) begin
      tick();
      n++;
    end
    check("j4_t5_a_lanes", bus.arr_a_flat[63:0], 64'h0000_2922_1B14_0D06);
    rst = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_arr_en", bus.arr_en, 0);
    check("midrst_arr_rst", bus.arr_rst, 1);
    check("midrst_lanes", |{bus.arr_a_flat, bus.arr_b_flat}, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_res_data", |bus.res_data, 0);
    rst = 1'b0;
    tick();
    check("midrst_release", bus.arr_rst, 0);

    // Buffers were cleared by reset: a job without reload yields zero.
    run_job(n);
    check("cleared_latency", 64'(n), 64'd54);
    check("cleared_result_zero", |bus.res_data, 0);
    tick();

    load_ops();
    run_job(n);
    check("j5_latency", 64'(n), 64'd54);
    check_res("j5_result");
    tick();
    check("j5_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_job_ctrl.md
Name: systolic_job_ctrl

Overview:
- Job controller for the 8x8 output-stationary systolic array.
- Holds the A and B operand matrices in local row buffers and clears the array before each job.
- Waits for the array to report locked, then streams the diagonally skewed A/B wavefronts with bubble cycles between them.
- After drain, captures the C matrix and returns it to the host over a valid/ready handshake.

Parameters:
- N, 8, array dimension (rows = cols = lanes).
- data_width, 8, operand element width.
- acc_width, 16, result element width (2*data_width).
- BUBBLE, 1, zero cycles inserted after each wavefront.
- CLR_CYCLES, 2, cycles arr_rst is held per job.
- DRAIN_CYCLES, 20, cycles arr_en stays high after the last wavefront before capture.
- LOCK_TIMEOUT, 255, maximum cycles spent waiting for arr_locked.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_wr_en  in  1  write one A row, A[wr_row][*].
- b_wr_en  in  1  write one B row, B[wr_row][*].
- wr_row  in  log2(N)  row index for the operand write.
- wr_data  in  N*data_width  row data; element j at bits [j*data_width +: data_width].
- wr_err  out  1  one-cycle pulse when an operand write is dropped.
- start  in  1  job request pulse/level.
- busy  out  1  high whenever state != IDLE.
- lock_err  out  1  sticky error; cleared by the next accepted start or by rst.
- res_valid  out  1  result available.
- res_ready  in  1  host accepts the result.
- res_data  out  N*N*acc_width  C[i][j] at element index i*N+j.
- arr_rst  out  1  array reset.
- arr_en  out  1  array enable.
- arr_locked  in  1  array ready indication.
- arr_a_flat  out  N*N*data_width  A lanes; lane i at bits [i*data_width +: data_width]; upper bits 0.
- arr_b_flat  out  N*N*data_width  B lanes, same packing as arr_a_flat.
- arr_c_flat  in  N*N*acc_width  array accumulators.

Behaviour:
- Reset: state IDLE; busy, res_valid, wr_err, lock_err, arr_en = 0; arr_a_flat, arr_b_flat = 0; res_data = 0; operand buffers cleared to 0. arr_rst is also driven high while rst is high, so the array is reset alongside the controller.
- Operand writes:
  - Accepted only in IDLE; write data is visible to the next job.
  - a_wr_en and b_wr_en together write both buffers with the same row and data.
  - A write outside IDLE is dropped and pulses wr_err for one cycle.
- start: sampled only in IDLE. Otherwise it is ignored, with no queueing and no error.
- FSM:
  - IDLE -> CLR on start. Clear lock_err, set busy.
  - CLR: arr_rst=1, arr_en=0 for CLR_CYCLES cycles, then -> LOCK.
  - LOCK:
    - arr_rst=0, arr_en=1, lanes 0.
    - arr_locked=1 -> FEED on the next edge.
    - If LOCK_TIMEOUT cycles elapse without arr_locked, set lock_err and go -> IDLE. No result is produced.
  - FEED:
    - Wavefront counter t runs 0..2N-2.
    - Each wavefront occupies 1 data cycle plus BUBBLE zero cycles.
    - Data cycle, lane i: A lane = A[i][t-i], B lane = B[t-i][i] when 0 <= t-i < N, else 0.
    - Bubble cycles drive all lanes to 0.
    - FEED lasts (2N-1)*(1+BUBBLE) cycles, 30 at defaults, then -> DRAIN.
  - DRAIN: arr_en=1, lanes 0 for DRAIN_CYCLES cycles, then -> CAPT.
  - CAPT: res_data <= arr_c_flat in a single cycle, arr_en=0, then -> DONE.
  - DONE:
    - res_valid=1; res_data and res_valid stay stable until res_ready.
    - A cycle with res_valid && res_ready -> IDLE; res_valid drops on the next edge.
    - res_ready may already be high on entry; the handshake then completes in one cycle.
- Outputs in IDLE and DONE: arr_en=0, arr_rst=0, lanes 0.
- Latency (defaults): res_valid rises CLR_CYCLES + L + 30 + DRAIN_CYCLES + 1 cycles after the start edge, where L = cycles spent in LOCK (L >= 1).
- Arithmetic: the controller moves data only and does no math; lane values are unmodified buffer contents.
- rst mid-job (any state): next edge returns to IDLE with the reset values above. The array is reset via arr_rst, and no partial result is presented.
- res_data is cleared only by rst; in IDLE it keeps the last captured result.

Test Plan:
- Load A[i][j] = 8i+j+1 and B[r][c] = 64-(8r+c), start with arr_locked tied high -> res_data C[0][0]=960, C[0][7]=708, C[7][0]=17088, C[7][7]=13700, all 64 match the golden product. res_valid rises exactly 2+1+30+20+1 = 54 cycles after start.
- Same job with res_ready held low for 10 cycles after res_valid -> res_data stable, busy=1, and a start pulse in this window is ignored. res_ready=1 -> IDLE next cycle.
- arr_locked held low -> lock_err=1 and state IDLE after 2+255 cycles, res_valid never asserted. Next start clears lock_err.
- a_wr_en pulse during FEED -> wr_err one-cycle pulse, buffer unchanged, result identical to the first job.
- Wavefront check at t=3, data cycle -> A lanes = {A[0][3], A[1][2], A[2][1], A[3][0], 0, 0, 0, 0} = {4, 11, 18, 25, 0...}. The following bubble cycle drives all lanes 0.
- rst asserted at FEED wavefront 5 -> next edge busy=0, arr_en=0, lanes 0, arr_rst high during rst. A subsequent fresh job, after reloading the cleared buffers with the same operands, yields the golden result.
